// File: rtl/embcpu4k_onchip_memory_dp.sv
// True dual-port RAM behind two Avalon-MM slaves on one clock, with s1-priority byte-lane
// collision resolution, a pipelined readdatavalid and an optional post-reset zero-clear sweep.
module embcpu4k_onchip_memory_dp #(
    parameter int    DATA_W         = 32,
    parameter int    ADDR_W         = 10,
    parameter int    READ_LATENCY   = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = "embcpu4k_onchip_memory_dp.hex"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    output logic                  init_done,
    output logic                  o_dbg_state,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAST  = READ_LATENCY - 1;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic                w_clr_we;
    logic                w_wait;
    logic                w_s1_acc, w_s2_acc, w_s1_wr, w_s2_wr;
    logic [1:0]          w_rd;
    logic [ADDR_W-1:0]   w_rd_addr [2];
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_pv [2][READ_LATENCY];
    logic [DATA_W-1:0]   r_pd [2][READ_LATENCY];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_we       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we       = 1'b1;
                w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
                if (r_clr_addr == '1) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign init_done      = (r_state == ST_RUN);
    assign o_dbg_state    = r_state;
    assign w_wait         = ~init_done;
    assign s1_waitrequest = w_wait;
    assign s2_waitrequest = w_wait;

    // A request with read and write both high is a write; it never produces readdatavalid.
    assign w_s1_acc     = reset_n & clken & ~w_wait & s1_chipselect & (s1_read | s1_write);
    assign w_s2_acc     = reset_n & clken & ~w_wait & s2_chipselect & (s2_read | s2_write);
    assign w_s1_wr      = w_s1_acc & s1_write;
    assign w_s2_wr      = w_s2_acc & s2_write;
    assign w_rd[0]      = w_s1_acc & s1_read & ~s1_write;
    assign w_rd[1]      = w_s2_acc & s2_read & ~s2_write;
    assign w_rd_addr[0] = s1_address;
    assign w_rd_addr[1] = s2_address;

    // s1 lanes are applied last so they win a same-address collision lane by lane.
    always_ff @(posedge clk) begin
        if (w_clr_we) r_mem[r_clr_addr] <= '0;
        for (int b = 0; b < BE_W; b++) begin
            if (w_s2_wr && s2_byteenable[b]) r_mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
        end
        for (int b = 0; b < BE_W; b++) begin
            if (w_s1_wr && s1_byteenable[b]) r_mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        end
    end

    // Reads sample the array before this edge's writes land, giving old-data read-during-write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < READ_LATENCY; s++) begin
                    r_pv[p][s] <= 1'b0;
                    r_pd[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_pv[p][0] <= w_rd[p];
                if (w_rd[p]) r_pd[p][0] <= r_mem[w_rd_addr[p]];
                for (int s = 1; s < READ_LATENCY; s++) begin
                    r_pv[p][s] <= r_pv[p][s-1];
                    if (r_pv[p][s-1]) r_pd[p][s] <= r_pd[p][s-1];
                end
            end
        end
    end

    assign s1_readdatavalid = r_pv[0][LAST];
    assign s1_readdata      = r_pd[0][LAST];
    assign s2_readdatavalid = r_pv[1][LAST];
    assign s2_readdata      = r_pd[1][LAST];

endmodule

// File: tb/tb_embcpu4k_onchip_memory_dp.sv
// Directed bench for embcpu4k_onchip_memory_dp: a READ_LATENCY=2 copy (a_*) and a
// READ_LATENCY=1 copy (b_*) share the same stimulus, both with ADDR_W=4 and clear-on-reset.
module tb_embcpu4k_onchip_memory_dp;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk, reset_n, clken;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write;
    logic          s2_chipselect, s2_read, s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic          a_init_done, a_dbg, a_s1_readdatavalid, a_s1_waitrequest, a_s2_readdatavalid, a_s2_waitrequest;
    logic [DW-1:0] a_s1_readdata, a_s2_readdata;
    logic          b_init_done, b_dbg, b_s1_readdatavalid, b_s1_waitrequest, b_s2_readdatavalid, b_s2_waitrequest;
    logic [DW-1:0] b_s1_readdata, b_s2_readdata;

    int n_cmp = 0;
    int n_fail = 0;

    embcpu4k_onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clken(clken), .init_done(a_init_done), .o_dbg_state(a_dbg),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(a_s1_readdata),
        .s1_readdatavalid(a_s1_readdatavalid), .s1_waitrequest(a_s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(a_s2_readdata),
        .s2_readdatavalid(a_s2_readdatavalid), .s2_waitrequest(a_s2_waitrequest)
    );

    embcpu4k_onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clken(clken), .init_done(b_init_done), .o_dbg_state(b_dbg),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(b_s1_readdata),
        .s1_readdatavalid(b_s1_readdatavalid), .s1_waitrequest(b_s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(b_s2_readdata),
        .s2_readdatavalid(b_s2_readdatavalid), .s2_waitrequest(b_s2_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic wr(input int port, input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (port == 1) begin
            s1_chipselect = 1; s1_write = 1; s1_address = addr; s1_writedata = data; s1_byteenable = be;
        end else begin
            s2_chipselect = 1; s2_write = 1; s2_address = addr; s2_writedata = data; s2_byteenable = be;
        end
        @(negedge clk);
        idle();
    endtask

    // Single read: the latency-1 copy answers one cycle after acceptance, the latency-2 copy one later.
    task automatic rd(input int port, input logic [3:0] addr, input logic [31:0] exp, input string nm);
        logic v;
        logic [31:0] d;
        if (port == 1) begin s1_chipselect = 1; s1_read = 1; s1_address = addr; end
        else begin s2_chipselect = 1; s2_read = 1; s2_address = addr; end
        @(negedge clk);
        idle();
        v = (port == 1) ? b_s1_readdatavalid : b_s2_readdatavalid;
        d = (port == 1) ? b_s1_readdata : b_s2_readdata;
        n_cmp++;
        if ({v, d} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL %s lat1 addr %0d: valid=%0b data=%08h, expected valid=1 data=%08h", nm, addr, v, d, exp);
        end
        v = (port == 1) ? a_s1_readdatavalid : a_s2_readdatavalid;
        n_cmp++;
        if (v !== 1'b0) begin
            n_fail++;
            $display("FAIL %s lat2_early addr %0d: valid=%0b, expected 0", nm, addr, v);
        end
        @(negedge clk);
        v = (port == 1) ? a_s1_readdatavalid : a_s2_readdatavalid;
        d = (port == 1) ? a_s1_readdata : a_s2_readdata;
        n_cmp++;
        if ({v, d} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL %s lat2 addr %0d: valid=%0b data=%08h, expected valid=1 data=%08h", nm, addr, v, d, exp);
        end
        v = (port == 1) ? b_s1_readdatavalid : b_s2_readdatavalid;
        d = (port == 1) ? b_s1_readdata : b_s2_readdata;
        n_cmp++;
        if ({v, d} !== {1'b0, exp}) begin
            n_fail++;
            $display("FAIL %s lat1_hold addr %0d: valid=%0b data=%08h, expected valid=0 data=%08h", nm, addr, v, d, exp);
        end
    endtask

    // Counts consecutive stalled cycles from the current negedge, bounded at 40.
    task automatic wait_clear(output int cyc, output bit stale);
        cyc = 0;
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_s1_waitrequest !== 1'b1) break;
            cyc++;
            if ((a_s1_readdatavalid === 1'b1) || (a_s2_readdatavalid === 1'b1) ||
                (b_s1_readdatavalid === 1'b1) || (b_s2_readdatavalid === 1'b1)) stale = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic check_in_reset(input string nm);
        n_cmp++;
        if ({a_init_done, b_init_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s init_done: a=%0b b=%0b, expected 0 0", nm, a_init_done, b_init_done);
        end
        n_cmp++;
        if ({a_s1_waitrequest, a_s2_waitrequest, b_s1_waitrequest, b_s2_waitrequest} !== 4'b1111) begin
            n_fail++;
            $display("FAIL %s waitrequest: %b, expected 1111", nm,
                     {a_s1_waitrequest, a_s2_waitrequest, b_s1_waitrequest, b_s2_waitrequest});
        end
        n_cmp++;
        if ({a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s readdatavalid: %b, expected 0000", nm,
                     {a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid});
        end
        n_cmp++;
        if ({a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL %s readdata: %h %h %h %h, expected all 0", nm,
                     a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata);
        end
    endtask

    task automatic check_clear(input string nm);
        int cyc;
        bit stale;
        wait_clear(cyc, stale);
        n_cmp++;
        if (cyc != 16) begin
            n_fail++;
            $display("FAIL %s clear_cycles: got %0d, expected 16", nm, cyc);
        end
        n_cmp++;
        if (stale) begin
            n_fail++;
            $display("FAIL %s stale_valid: got 1, expected 0 during clear", nm);
        end
        n_cmp++;
        if ({a_init_done, b_init_done, b_s1_waitrequest, a_s2_waitrequest} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s run_state: init_done a/b=%0b%0b wait b1/a2=%0b%0b, expected 11 00", nm,
                     a_init_done, b_init_done, b_s1_waitrequest, a_s2_waitrequest);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clken   = 1'b1;
        idle();
        @(negedge clk);
        check_in_reset("reset");
        reset_n = 1'b1;
        check_clear("reset");
        for (int i = 0; i < 16; i++) rd((i % 2) + 1, 4'(i), 32'h0, "clear_rd");
    endtask

    task automatic test_byteenable();
        wr(1, 4'd5, 32'hAABBCCDD, 4'b0101);
        rd(2, 4'd5, 32'h00BB00DD, "be_partial");
        wr(2, 4'd5, 32'hFFFFFFFF, 4'b0000);
        rd(1, 4'd5, 32'h00BB00DD, "be_zero");
    endtask

    task automatic test_collision();
        s1_chipselect = 1; s1_write = 1; s1_address = 4'd3; s1_writedata = 32'h11111111; s1_byteenable = 4'b0011;
        s2_chipselect = 1; s2_write = 1; s2_address = 4'd3; s2_writedata = 32'h22222222; s2_byteenable = 4'b1110;
        @(negedge clk);
        idle();
        rd(1, 4'd3, 32'h22221111, "collision");
    endtask

    task automatic test_read_during_write();
        wr(1, 4'd7, 32'h12345678, 4'b1111);
        s1_chipselect = 1; s1_write = 1; s1_address = 4'd7; s1_writedata = 32'hDEADBEEF; s1_byteenable = 4'b1111;
        s2_chipselect = 1; s2_read = 1; s2_address = 4'd7;
        @(negedge clk);
        idle();
        n_cmp++;
        if ({b_s2_readdatavalid, b_s2_readdata} !== {1'b1, 32'h12345678}) begin
            n_fail++;
            $display("FAIL rdw_old lat1: valid=%0b data=%08h, expected valid=1 data=12345678",
                     b_s2_readdatavalid, b_s2_readdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_s2_readdatavalid, a_s2_readdata} !== {1'b1, 32'h12345678}) begin
            n_fail++;
            $display("FAIL rdw_old lat2: valid=%0b data=%08h, expected valid=1 data=12345678",
                     a_s2_readdatavalid, a_s2_readdata);
        end
        rd(2, 4'd7, 32'hDEADBEEF, "rdw_new");
    endtask

    task automatic test_read_and_write();
        s1_chipselect = 1; s1_read = 1; s1_write = 1; s1_address = 4'd9;
        s1_writedata = 32'h0BADF00D; s1_byteenable = 4'b1111;
        @(negedge clk);
        idle();
        n_cmp++;
        if (b_s1_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_both lat1: valid=%0b, expected 0", b_s1_readdatavalid);
        end
        @(negedge clk);
        n_cmp++;
        if (a_s1_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_both lat2: valid=%0b, expected 0", a_s1_readdatavalid);
        end
        rd(1, 4'd9, 32'h0BADF00D, "rw_both_data");
    endtask

    task automatic test_clken();
        clken = 1'b0;
        s1_chipselect = 1; s1_write = 1; s1_address = 4'd10; s1_writedata = 32'hCAFE0010; s1_byteenable = 4'b1111;
        s2_chipselect = 1; s2_read = 1; s2_address = 4'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_s1_waitrequest, b_s2_waitrequest, a_s2_readdatavalid, b_s2_readdatavalid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL clken_off cycle %0d: wait a1/b2=%0b%0b valid a2/b2=%0b%0b, expected 0000", i,
                         a_s1_waitrequest, b_s2_waitrequest, a_s2_readdatavalid, b_s2_readdatavalid);
            end
        end
        idle();
        clken = 1'b1;
        rd(2, 4'd10, 32'h0, "clken_unchanged");
        clken = 1'b0;
        s1_chipselect = 1; s1_write = 1; s1_address = 4'd11; s1_writedata = 32'hCAFE0011; s1_byteenable = 4'b1111;
        repeat (3) @(negedge clk);
        clken = 1'b1;
        @(negedge clk);
        idle();
        rd(2, 4'd11, 32'hCAFE0011, "clken_commit");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) wr(2, 4'(i), 32'hC0DE0000 + 32'(i), 4'b1111);
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 8) begin
                s1_chipselect = 1; s1_read = 1; s1_address = 4'(c);
                s2_chipselect = 1; s2_read = 1; s2_address = 4'(7 - c);
            end
            @(negedge clk);
            n_cmp++;
            if (c < 8) begin
                if ({b_s1_readdatavalid, b_s1_readdata, b_s2_readdatavalid, b_s2_readdata} !==
                    {1'b1, 32'hC0DE0000 + 32'(c), 1'b1, 32'hC0DE0000 + 32'(7 - c)}) begin
                    n_fail++;
                    $display("FAIL b2b lat1 cycle %0d: s1 %0b/%08h s2 %0b/%08h, expected 1/%08h 1/%08h", c,
                             b_s1_readdatavalid, b_s1_readdata, b_s2_readdatavalid, b_s2_readdata,
                             32'hC0DE0000 + 32'(c), 32'hC0DE0000 + 32'(7 - c));
                end
            end else if ({b_s1_readdatavalid, b_s2_readdatavalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b lat1_tail cycle %0d: valid=%0b%0b, expected 00", c,
                         b_s1_readdatavalid, b_s2_readdatavalid);
            end
            if (c >= 1 && c <= 8) begin
                n_cmp++;
                if ({a_s1_readdatavalid, a_s1_readdata, a_s2_readdatavalid, a_s2_readdata} !==
                    {1'b1, 32'hC0DE0000 + 32'(c - 1), 1'b1, 32'hC0DE0000 + 32'(8 - c)}) begin
                    n_fail++;
                    $display("FAIL b2b lat2 cycle %0d: s1 %0b/%08h s2 %0b/%08h, expected 1/%08h 1/%08h", c,
                             a_s1_readdatavalid, a_s1_readdata, a_s2_readdatavalid, a_s2_readdata,
                             32'hC0DE0000 + 32'(c - 1), 32'hC0DE0000 + 32'(8 - c));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 5; c++) begin
            s1_chipselect = 1; s1_read = 1; s1_address = 4'(c);
            reset_n = (c != 4);
            @(negedge clk);
            if (c < 4) begin
                n_cmp++;
                if ({b_s1_readdatavalid, b_s1_readdata} !== {1'b1, 32'hC0DE0000 + 32'(c)}) begin
                    n_fail++;
                    $display("FAIL burst lat1 cycle %0d: valid=%0b data=%08h, expected valid=1 data=%08h", c,
                             b_s1_readdatavalid, b_s1_readdata, 32'hC0DE0000 + 32'(c));
                end
            end
        end
        check_in_reset("mid_reset");
        reset_n = 1'b1;
        s1_chipselect = 1; s1_read = 1; s1_address = 4'd4;
        s2_chipselect = 1; s2_write = 1; s2_address = 4'd2; s2_writedata = 32'h5A5A0002; s2_byteenable = 4'b1111;
        check_clear("mid_reset");
        @(negedge clk);
        idle();
        n_cmp++;
        if ({b_s1_readdatavalid, b_s1_readdata} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL held_read lat1: valid=%0b data=%08h, expected valid=1 data=00000000",
                     b_s1_readdatavalid, b_s1_readdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_s1_readdatavalid, a_s1_readdata} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL held_read lat2: valid=%0b data=%08h, expected valid=1 data=00000000",
                     a_s1_readdatavalid, a_s1_readdata);
        end
        rd(1, 4'd2, 32'h5A5A0002, "held_write");
        rd(2, 4'd5, 32'h0, "reclear");
    endtask

    initial begin
        test_reset();
        test_byteenable();
        test_collision();
        test_read_during_write();
        test_read_and_write();
        test_clken();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
